ph_reg3: RTL
============

# ph_reg3

Parasite-to-host register 3 of the Tube: a 2-byte FIFO for fast 16-bit block transfers from the parasite CPU to the host. The parasite writes through the register-3 data port and the host reads through its register-3 data port. Each slot's full/available state is held as a pair of toggle bits, one per clock domain, so each domain updates only its own half. `one_byte_mode` (V flag) collapses the FIFO to a single-byte latch.

## Interface
- No parameters.
- `h_phi2` in 1: host clock; host reads complete on the falling edge.
- `h_rst_b` in 1: reset, asynchronous, active-low; clears both domains' state.
- `h_rdnw` in 1: host read (1) / write (0) qualifier.
- `h_selectData` in 1: host has selected the register-3 data address.
- `h_data` out 8: read data, combinational from slot registers.
- `h_data_available` out 1: data ready for host.
- `h_two_bytes_available` out 1: both slots full, two-byte mode only.
- `p_selectData` in 1: parasite has selected the register-3 data address.
- `p_wrstb_b` in 1: parasite write strobe, active-low. Present only without `PH_REG3_RNWCLK_EN`.
- `p_phi2` in 1: parasite clock. Present only with `PH_REG3_RNWCLK_EN`.
- `p_rdnw` in 1: parasite read/write qualifier. Present only with `PH_REG3_RNWCLK_EN`.
- `p_data` in 8: parasite write data.
- `one_byte_mode` in 1: 1 = single-byte latch behaviour.
- `p_full` out 1: register full, as seen by the parasite.

## Operation
- **State:**
  - `byte0`, `byte1` (8b each), parasite domain.
  - Toggles `p_tog[1:0]` (parasite domain) and `h_tog[1:0]` (host domain).
  - Slot flags `f[i] = p_tog[i] ^ h_tog[i]`.
- **Parasite write event:** `p_selectData` and a write strobe. Slot selection:
  - Slot 0 is written when `!f[0] | one_byte_mode`.
  - Slot 1 is written when `f[0] & !one_byte_mode`.
  - The selected `byteN` is loaded from `p_data`.
  - `p_tog[N]` toggles only if `f[N]==0`.
  - Writing a full slot overwrites its data and leaves the flag set. This covers one-byte-mode overwrite and a third write in two-byte mode.
- **Host read event:** `h_selectData & h_rdnw` at the `h_phi2` falling edge.
  - If `f[0]`, `h_tog[0]` toggles.
  - Otherwise, if `f[1] & !one_byte_mode`, `h_tog[1]` toggles.
  - A read while empty changes no state.
- **Outputs:**
  - `h_data = f[0] ? byte0 : byte1`
  - `h_data_available = (f[0] & one_byte_mode) | f[1]`
  - `h_two_bytes_available = !one_byte_mode & f[0] & f[1]`
  - `p_full = one_byte_mode ? f[0] : f[1]`
- **Two-byte semantics:**
  - Available asserts only after the second byte is written and stays asserted until the second byte is read.
  - `p_full` stays asserted until both bytes are read.
- **Mode change:** a mid-transfer `one_byte_mode` change retains flags and data; outputs re-evaluate combinationally.
- **Reset:** all toggles 0, `byte0 = byte1 = 8'h00`. Resulting output values:
  - `h_data` = 0
  - `h_data_available` = 0
  - `h_two_bytes_available` = 0
  - `p_full` = 0

## Timing
- **Parasite write, strobe mode:** data and toggle are captured on the rising edge of `p_wrstb_b` when `p_selectData` is high.
- **Host read:** the toggle updates on the `h_phi2` falling edge that ends the read cycle. `h_data` is valid during that cycle, with no read latency.
- **Flag latency:** flags are combinational XORs, so the opposite domain sees a flag change immediately after the owning edge. Each consumer synchronises flags in its own domain.
- **Concurrent events:** a parasite write and a host read in the same period touch disjoint registers, so no event is lost.
- **Read/write race:** a host read of slot 0 concurrent with a parasite write to slot 0 is a protocol violation. The parasite waits for `!p_full`.

## Configuration
- **`PH_REG3_RNWCLK_EN` defined:**
  - The parasite interface is `p_phi2` / `p_rdnw`.
  - A write occurs at the falling edge of `p_phi2` when `p_selectData & !p_rdnw`.
  - `p_wrstb_b` is absent.
- **`PH_REG3_RNWCLK_EN` undefined:**
  - The parasite interface is the `p_wrstb_b` strobe, with writes on its rising edge.
  - `p_phi2` and `p_rdnw` are absent.

## Test plan
- **Reset:** assert `h_rst_b=0` mid-transfer with `f=2'b11`. Required: all outputs 0, `h_data=8'h00`; after release, the first write goes to slot 0.
- **Two-byte mode (`one_byte_mode=0`):** parasite writes `8'hA5`, then `8'h5A`.
  - After the first write: `h_data_available=0`, `p_full=0`.
  - After the second write: `h_data_available=1`, `h_two_bytes_available=1`, `p_full=1`.
  - Host reads `8'hA5` then `8'h5A`; `h_data_available` and `p_full` drop only after the second read.
- **One-byte mode:** write `8'h11` → `h_data_available=1`, `p_full=1`. Then write `8'h22` without a host read → host reads `8'h22`, then all flags 0.
- **Empty read:** host read with `f=0` → no toggle change, `h_data_available` stays 0.
- **Third write in two-byte mode:** slots full, parasite writes `8'h33` → `byte1=8'h33`, flags unchanged. Host reads byte0, then `8'h33`.
- **Both configurations:** repeat the two-byte scenario with `PH_REG3_RNWCLK_EN` defined and undefined. Writes with `p_rdnw=1`, or with `p_selectData=0`, are ignored.

Source files
------------

// File: rtl/ph_reg3.sv
// Tube parasite-to-host register 3: two-slot byte FIFO with per-domain toggle flags.
// Define PH_REG3_RNWCLK_EN for a p_phi2/p_rdnw parasite bus instead of the p_wrstb_b strobe.
module ph_reg3 (
  input  logic       h_phi2,
  input  logic       h_rst_b,
  input  logic       h_rdnw,
  input  logic       h_selectData,
  output logic [7:0] h_data,
  output logic       h_data_available,
  output logic       h_two_bytes_available,
  input  logic       p_selectData,
`ifdef PH_REG3_RNWCLK_EN
  input  logic       p_phi2,
  input  logic       p_rdnw,
`else
  input  logic       p_wrstb_b,
`endif
  input  logic [7:0] p_data,
  input  logic       one_byte_mode,
  output logic       p_full
);

  logic [7:0] r_byte0;
  logic [7:0] r_byte1;
  logic [1:0] r_p_tog;
  logic [1:0] r_h_tog;
  logic [1:0] w_f;
  logic       w_p_we;
  logic       w_slot1;
  logic       w_h_rd;

  // A slot is full while the two domains' toggles disagree.
  assign w_f     = r_p_tog ^ r_h_tog;
  assign w_slot1 = w_f[0] & ~one_byte_mode;
  assign w_h_rd  = h_selectData & h_rdnw;

`ifdef PH_REG3_RNWCLK_EN
  assign w_p_we = p_selectData & ~p_rdnw;
`else
  assign w_p_we = p_selectData;
`endif

  // Parasite domain: data bytes and parasite-side toggles.
`ifdef PH_REG3_RNWCLK_EN
  always_ff @(negedge p_phi2 or negedge h_rst_b) begin
`else
  always_ff @(posedge p_wrstb_b or negedge h_rst_b) begin
`endif
    if (!h_rst_b) begin
      r_byte0 <= 8'h00;
      r_byte1 <= 8'h00;
      r_p_tog <= 2'b00;
    end else if (w_p_we) begin
      if (w_slot1) begin
        r_byte1 <= p_data;
        if (!w_f[1]) r_p_tog[1] <= ~r_p_tog[1];
      end else begin
        r_byte0 <= p_data;
        if (!w_f[0]) r_p_tog[0] <= ~r_p_tog[0];
      end
    end
  end

  // Host domain: a read drains slot 0 first, then slot 1.
  always_ff @(negedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      r_h_tog <= 2'b00;
    end else if (w_h_rd) begin
      if (w_f[0])
        r_h_tog[0] <= ~r_h_tog[0];
      else if (w_f[1] & ~one_byte_mode)
        r_h_tog[1] <= ~r_h_tog[1];
    end
  end

  assign h_data                = w_f[0] ? r_byte0 : r_byte1;
  assign h_data_available      = (w_f[0] & one_byte_mode) | w_f[1];
  assign h_two_bytes_available = ~one_byte_mode & w_f[0] & w_f[1];
  assign p_full                = one_byte_mode ? w_f[0] : w_f[1];

endmodule
